// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with pipeline stall sequencing
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator; signs are fixed up on entry to DONE.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [2:0]         op;
  logic               sign_a;
  logic               sign_b;

  logic               signed_a, signed_b, in_sa, in_sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div_zero, div_ovf, special;
  logic [WIDTH-1:0]   special_res;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, step, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    signed_a    = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    signed_b    = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    in_sa       = signed_a & SrcA[WIDTH-1];
    in_sb       = signed_b & SrcB[WIDTH-1];
    mag_a       = in_sa ? -SrcA : SrcA;
    mag_b       = in_sb ? -SrcB : SrcB;
    div_zero    = (SrcB == '0);
    div_ovf     = signed_b && Funct3[2] && (SrcA == MIN_NEG) && (SrcB == '1);
    special     = Funct3[2] && (div_zero || div_ovf);
    special_res = '0;
    if (div_zero)
      special_res = Funct3[1] ? SrcA : '1;
    else if (div_ovf)
      special_res = Funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration of either algorithm; the divide keeps {rem, quot} in the accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_part = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_part - {1'b0, mcand};
    div_next = {div_diff[WIDTH] ? div_part[WIDTH-1:0] : div_diff[WIDTH-1:0],
                acc[WIDTH-2:0], ~div_diff[WIDTH]};
    step     = op[2] ? div_next : mul_next;
  end

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -step : step;
    quot_fix = (sign_a ^ sign_b) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem_fix  = sign_a ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    case (op)
      3'b000:                 final_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         final_res = quot_fix;
      default:                final_res = rem_fix;
    endcase
  end

  assign stall = ((state == IDLE) && start && !flush) || (state == CALC);
  assign busy  = (state == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      Result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            op     <= Funct3;
            sign_a <= in_sa;
            sign_b <= in_sb;
            mcand  <= mag_b;
            if (special) begin
              Result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              acc   <= {{WIDTH{1'b0}}, mag_a};
              count <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc   <= step;
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              Result <= final_res;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          // The instruction has already retired, so flush cannot cancel this pulse.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
// Expected results are queued at issue and popped by a monitor when done pulses.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        stall, busy, done;
  logic [31:0] Result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .stall(stall), .busy(busy), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: Result=%h, no result was expected", Result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (Result !== e) begin
          n_bad++;
          $display("FAIL result: got %h expected %h", Result, e);
        end
      end
    end
  end

  // Issues one op in cycle 0 and tracks stall/busy shape against the expected latency.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat,
                        output int done_cyc, output int bad);
    exp_q.push_back(exp);
    last_exp = exp;
    done_cyc = -1;
    bad = 0;
    @(posedge clk); #1;
    start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
    for (int c = 0; c < lat + 4 && done_cyc < 0; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      @(negedge clk);
      if (stall !== (c < lat)) bad++;
      if (busy !== (lat > 1 && c >= 1 && c < lat)) bad++;
      if (done === 1'b1) done_cyc = c;
    end
    start = 1'b0;
    if (done_cyc < 0) exp_q.delete();
  endtask

  task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
    int dc, bad;
    run_op(f3, a, b, exp, lat, dc, bad);
    n_cmp++;
    if (dc !== lat) begin
      n_bad++;
      $display("FAIL %s_latency: done in cycle %0d, expected cycle %0d", name, dc, lat);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL %s_stall_busy: %0d bad cycles, expected 0", name, bad);
    end
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if (stall !== 1'b0)  begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (Result !== '0)   begin n_bad++; $display("FAIL reset_result: got %h expected 0", Result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul;
    check_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    check_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    check_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    check_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
  endtask

  task automatic test_div;
    check_op("divu", 3'b101, 32'd100,      32'd7, 32'd14,       33);
    check_op("remu", 3'b111, 32'd100,      32'd7, 32'd2,        33);
    check_op("div",  3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);
    check_op("rem",  3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
  endtask

  task automatic test_special;
    check_op("div_zero", 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    check_op("rem_zero", 3'b110, 32'd5,        32'd0,        32'd5,        1);
    check_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    check_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
  endtask

  task automatic test_flush;
    logic [31:0] prior;
    prior = last_exp;
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_idle_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      flush = (c == 10);
      @(negedge clk);
      if (c == 11) begin
        n_cmp++; if (busy !== 1'b0 || stall !== 1'b0)
          begin n_bad++; $display("FAIL flush_calc_idle: busy=%b stall=%b expected 0/0", busy, stall); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_calc_done: got %b expected 0", done); end
        n_cmp++; if (Result !== prior)
          begin n_bad++; $display("FAIL flush_result_held: got %h expected %h", Result, prior); end
      end
    end
    flush = 1'b0;
    check_op("after_flush", 3'b000, 32'd12345, 32'd678, 32'd8369910, 33);
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'b101; SrcA = 32'd1000; SrcB = 32'd3;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pre_reset_busy: got %b expected 1", busy); end
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0)
      begin n_bad++; $display("FAIL async_reset_ctl: busy=%b stall=%b done=%b expected 0", busy, stall, done); end
    n_cmp++; if (Result !== '0) begin n_bad++; $display("FAIL async_reset_result: got %h expected 0", Result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    check_op("b2b_mul",  3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33);
    check_op("b2b_divu", 3'b101, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 33);
    check_op("b2b_remu", 3'b111, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_async_reset();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d results never produced, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
